// File: rtl/pp_pkg.sv
// Shared types and helpers for the iterative partial-product reduction engine.
package pp_pkg;

  localparam int unsigned NUM_PP_MAX = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REDUCE = 2'd1,
    DONE   = 2'd2
  } state_e;

  // Smallest r with 2**r >= v.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((r < 32) && ((33'd1 << r) < 33'(v))) r++;
    return r;
  endfunction

endpackage

// File: rtl/pp_compressor_row.sv
// One row of WIDTH 4:2 compressors; inter-column carry ripples one bit, top carry dropped.
module pp_compressor_row
  import pp_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] craw
);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] cout;
  logic [WIDTH-1:0] cin;

  // cout depends only on a/b/c, so the lateral chain never grows past one column.
  always_comb begin
    s1   = a ^ b ^ c;
    cout = (a & b) | (a & c) | (b & c);
    cin  = cout << 1;
    s    = s1 ^ d ^ cin;
    craw = (s1 & d) | (s1 & cin) | (d & cin);
  end

endmodule

// File: rtl/pp_reduce_iter.sv
// Iterative partial-product reducer: one shared 4:2 row removes two rows per cycle
// until a single sum/carry pair remains.
module pp_reduce_iter
  import pp_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int NUM_PP = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_PP*WIDTH-1:0]  pp_i,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         sum_o,
  output logic [WIDTH-1:0]         carry_o,
  output logic                     busy
);

  localparam int unsigned CW = clog2(32'(NUM_PP) + 32'd1);

  if (NUM_PP < 2 || NUM_PP > int'(NUM_PP_MAX)) begin : g_bad_num_pp
    $error("pp_reduce_iter: NUM_PP out of range 2..32");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] row_q [NUM_PP];
  logic [WIDTH-1:0] row_d [NUM_PP];
  logic [WIDTH-1:0] sh3   [NUM_PP];
  logic [WIDTH-1:0] sh4   [NUM_PP];
  logic [CW-1:0]    count_q, count_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] op_c, op_d, cmp_s, cmp_craw, cmp_c;
  logic             full_step;
  int unsigned      cnt, base;

  if (NUM_PP >= 3) begin : g_op_c
    assign op_c = row_q[2];
  end else begin : g_no_op_c
    assign op_c = '0;
  end

  if (NUM_PP >= 4) begin : g_op_d
    assign op_d = full_step ? row_q[3] : '0;
  end else begin : g_no_op_d
    assign op_d = '0;
  end

  pp_compressor_row #(.WIDTH(WIDTH)) u_row (
    .a    (row_q[0]),
    .b    (row_q[1]),
    .c    (op_c),
    .d    (op_d),
    .s    (cmp_s),
    .craw (cmp_craw)
  );

  assign cmp_c = cmp_craw << 1;

  // Row queue viewed after dropping the 3 or 4 consumed entries.
  always_comb begin
    for (int j = 0; j < NUM_PP; j++) begin
      sh3[j] = '0;
      sh4[j] = '0;
    end
    for (int j = 0; j + 3 < NUM_PP; j++) sh3[j] = row_q[j+3];
    for (int j = 0; j + 4 < NUM_PP; j++) sh4[j] = row_q[j+4];
  end

  // Row queue and count update.
  always_comb begin
    row_d     = row_q;
    count_d   = count_q;
    cnt       = 32'(count_q);
    full_step = (cnt >= 32'd4);
    base      = full_step ? (cnt - 32'd4) : (cnt - 32'd3);
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          for (int k = 0; k < NUM_PP; k++) row_d[k] = pp_i[k*WIDTH +: WIDTH];
          count_d = CW'(NUM_PP);
        end
      end
      REDUCE: begin
        for (int j = 0; j < NUM_PP; j++) begin
          row_d[j] = full_step ? sh4[j] : sh3[j];
          if (32'(j) == base)              row_d[j] = cmp_s;
          else if (32'(j) == base + 32'd1) row_d[j] = cmp_c;
        end
        count_d = (cnt == 32'd3) ? CW'(2) : (count_q - CW'(2));
      end
      default: ;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = (NUM_PP == 2) ? DONE : REDUCE;
      REDUCE:  if (count_d == CW'(2)) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake/status flags follow the upcoming state so they come straight from flops.
  always_comb begin
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      for (int k = 0; k < NUM_PP; k++) row_q[k] <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      for (int k = 0; k < NUM_PP; k++) row_q[k] <= row_d[k];
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign sum_o     = row_q[0];
  assign carry_o   = row_q[1];

endmodule
